i2s_audio_receiver: RTL and testbench
=====================================

# i2s_audio_receiver

Serial-audio receiver for the Computer_System audio path. It is the capture counterpart of the audio subsystem's I2S transmitter (BCLK/LRCLK/DACDAT). The block oversamples an external I2S stream (BCLK, LRCLK, DIN) in the system clock domain and deserializes stereo frames. It buffers the frames in a small FIFO and presents them on a valid/ready stream for the audio subsystem's ADC-side register interface.

## Interface
- DATA_WIDTH, 24: bits kept per channel (MSB-aligned); legal 16..32.
- FIFO_DEPTH, 4: stereo frames buffered; power of two, 2..16.
- clk  in  1  system clock; all logic on rising edge; must be ≥ 8× BCLK.
- reset_n  in  1  asynchronous, active-low reset.
- enable  in  1  receiver enable; low forces UNLOCKED, drops partial frame, keeps FIFO contents.
- i2s_bclk  in  1  asynchronous serial bit clock (from pin).
- i2s_lrclk  in  1  asynchronous word select; 0 = left, 1 = right.
- i2s_din  in  1  asynchronous serial data, MSB first.
- out_left  out  DATA_WIDTH  left sample at FIFO head.
- out_right  out  DATA_WIDTH  right sample at FIFO head.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head frame when out_valid & out_ready.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  frames stored.
- locked  out  1  receiver aligned to a frame boundary.
- overrun  out  1  sticky; a completed frame was dropped because the FIFO was full.
- overrun_clear  in  1  one-cycle pulse that clears overrun.

## Operation
- i2s_bclk, i2s_lrclk and i2s_din each pass through a 2-flop synchronizer. A third bclk flop provides rising-edge detection (bclk_rise). All sampling is done on bclk_rise only.
- On bclk_rise: lr = synced LRCLK and d = synced DIN; lr_prev holds the lr value from the previous bclk_rise.
- State machine:
  - UNLOCKED: on bclk_rise with lr_prev=1, lr=0 → LEFT; bit_cnt=0; locked=1. The din bit on that edge is discarded.
  - LEFT: on bclk_rise with lr==lr_prev:
    - if bit_cnt<DATA_WIDTH, shift d into shreg at bit position DATA_WIDTH-1-bit_cnt.
    - bit_cnt increments, saturating at 63.
    - On lr 0→1: this edge's d is the last bit of the left slot and is captured under the same rule. Then left_hold=shreg, shreg=0, bit_cnt=0, state → RIGHT.
  - RIGHT: same capture rule. On lr 1→0: the last bit is captured, then the frame {left_hold, shreg} is committed and the state returns to LEFT with shreg=0.
  - Any state, enable=0: → UNLOCKED next cycle; shreg, bit_cnt and left_hold cleared; locked=0.
- The one-BCLK I2S data delay follows from the above: the MSB is the first bclk_rise after the LRCLK change.
- Width rules:
  - Slot shorter than DATA_WIDTH: unfilled LSBs are zero.
  - Slot longer than DATA_WIDTH: extra LSBs are ignored.
  - No sign extension or rounding.
- Commit: write to the FIFO when fifo_level<FIFO_DEPTH, or when fifo_level==FIFO_DEPTH and a pop occurs in the same cycle. Otherwise the frame is dropped and overrun is set.
- overrun: overrun_clear clears it; a set in the same cycle takes priority.
- FIFO order: first-in first-out. out_left/out_right are the head entry and stay stable while out_valid=1 and out_ready=0.
- Simultaneous push and pop: fifo_level is unchanged.

## Timing
- Reset values: out_left=0, out_right=0, out_valid=0, fifo_level=0, locked=0, overrun=0. State is UNLOCKED, and the synchronizer and lr_prev flops are 0.
- bclk_rise is asserted 3 clk cycles after the first clk edge that registers the pin-level BCLK high. It is high for exactly one clk cycle.
- Commit occurs on the clk edge after bclk_rise. The FIFO write and fifo_level update occur on the following edge.
- out_valid rises 5 clk cycles after the first clk edge that registers the closing BCLK rise of the right slot.
- Pop: on a clk edge where out_valid & out_ready, the head advances and the new head/out_valid are visible on the next cycle.
- Back-to-back pops are supported every cycle.
- reset_n low mid-frame clears everything asynchronously. After release, the receiver re-locks at the next LRCLK falling edge; no partial frame is emitted.
- locked rises on the clk edge following the locking bclk_rise.

## Test plan
- DATA_WIDTH=24, BCLK=clk/16, 32-bit slots, left word 0xA5A5A5A5, right word 0x12345678 → one frame: out_left=0xA5A5A5, out_right=0x123456. out_valid rises 5 clk after the closing BCLK rise.
- Enable mid right slot → no frame from the partial slot. locked rises after the first LRCLK 1→0. The first emitted frame is the next full left/right pair.
- 16-bit slots, left 0xBEEF, right 0x0001 → out_left=0xBEEF00, out_right=0x000100.
- FIFO_DEPTH=4, out_ready=0, 5 frames L=n, R=n+0x100 (n=1..5) → fifo_level=4, overrun=1. Draining yields frames 1..4 in order; frame 5 is absent.
- Assert reset_n low for 3 clk in the middle of a left slot → all outputs at reset values. The next full frame after re-lock is correct.
- overrun_clear pulsed in the same cycle as a dropped commit → overrun stays 1. A pulse in a later quiet cycle → overrun=0.

Source files
------------

// File: rtl/i2s_audio_receiver.sv
// I2S stereo capture: oversamples BCLK/LRCLK/DIN in the clk domain, deserializes
// MSB-aligned left/right words and queues complete frames on a valid/ready stream.
module i2s_audio_receiver #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               enable,
  input  logic                               i2s_bclk,
  input  logic                               i2s_lrclk,
  input  logic                               i2s_din,
  output logic [DATA_WIDTH-1:0]              out_left,
  output logic [DATA_WIDTH-1:0]              out_right,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_level,
  output logic                               locked,
  output logic                               overrun,
  input  logic                               overrun_clear
);

  localparam int          LVL_W = $clog2(FIFO_DEPTH + 1);
  localparam int          PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned DW    = DATA_WIDTH;

  typedef enum logic [1:0] {UNLOCKED, LEFT, RIGHT} state_t;

  logic [1:0] bclk_sync, lr_sync, din_sync;
  logic       bclk_d, bclk_rise, lr, d, lr_prev;

  // lr/d are captured together with the rise strobe so they stay aligned with it
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bclk_sync <= '0;
      lr_sync   <= '0;
      din_sync  <= '0;
      bclk_d    <= 1'b0;
      bclk_rise <= 1'b0;
      lr        <= 1'b0;
      d         <= 1'b0;
      lr_prev   <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], i2s_bclk};
      lr_sync   <= {lr_sync[0], i2s_lrclk};
      din_sync  <= {din_sync[0], i2s_din};
      bclk_d    <= bclk_sync[1];
      bclk_rise <= bclk_sync[1] & ~bclk_d;
      if (bclk_sync[1] & ~bclk_d) begin
        lr <= lr_sync[1];
        d  <= din_sync[1];
      end
      if (bclk_rise) lr_prev <= lr;
    end
  end

  state_t                state;
  logic [DATA_WIDTH-1:0] shreg, shreg_cap, left_hold, bit_mask;
  logic [5:0]            bit_cnt, bit_cnt_inc;
  logic                  commit;
  logic [DATA_WIDTH-1:0] commit_left, commit_right;

  always_comb begin
    bit_mask    = (32'(bit_cnt) < DW) ? (DATA_WIDTH'(1) << (DW - 1 - 32'(bit_cnt))) : '0;
    shreg_cap   = d ? (shreg | bit_mask) : (shreg & ~bit_mask);
    bit_cnt_inc = (bit_cnt == 6'd63) ? bit_cnt : bit_cnt + 6'd1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= UNLOCKED;
      shreg        <= '0;
      left_hold    <= '0;
      bit_cnt      <= '0;
      locked       <= 1'b0;
      commit       <= 1'b0;
      commit_left  <= '0;
      commit_right <= '0;
    end else begin
      commit <= 1'b0;
      if (!enable) begin
        state     <= UNLOCKED;
        shreg     <= '0;
        left_hold <= '0;
        bit_cnt   <= '0;
        locked    <= 1'b0;
      end else if (bclk_rise) begin
        case (state)
          UNLOCKED: begin
            if (lr_prev && !lr) begin
              state   <= LEFT;
              shreg   <= '0;
              bit_cnt <= '0;
              locked  <= 1'b1;
            end
          end
          LEFT: begin
            if (lr && !lr_prev) begin
              left_hold <= shreg_cap;
              shreg     <= '0;
              bit_cnt   <= '0;
              state     <= RIGHT;
            end else begin
              shreg   <= shreg_cap;
              bit_cnt <= bit_cnt_inc;
            end
          end
          RIGHT: begin
            if (!lr && lr_prev) begin
              commit       <= 1'b1;
              commit_left  <= left_hold;
              commit_right <= shreg_cap;
              shreg        <= '0;
              bit_cnt      <= '0;
              state        <= LEFT;
            end else begin
              shreg   <= shreg_cap;
              bit_cnt <= bit_cnt_inc;
            end
          end
          default: state <= UNLOCKED;
        endcase
      end
    end
  end

  logic [DATA_WIDTH-1:0] mem_left  [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_right [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  pop, push, full;

  always_comb begin
    out_valid = (fifo_level != '0);
    out_left  = mem_left[rd_ptr];
    out_right = mem_right[rd_ptr];
    pop       = out_valid & out_ready;
    full      = (fifo_level == LVL_W'(FIFO_DEPTH));
    push      = commit & (~full | pop);
  end

  // pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mem_left   <= '{default: '0};
      mem_right  <= '{default: '0};
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overrun    <= 1'b0;
    end else begin
      if (push) begin
        mem_left[wr_ptr]  <= commit_left;
        mem_right[wr_ptr] <= commit_right;
        wr_ptr            <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (commit && !push)    overrun <= 1'b1;
      else if (overrun_clear) overrun <= 1'b0;
    end
  end

endmodule

// File: tb/tb_i2s_audio_receiver.sv
// Bench for i2s_audio_receiver: drives I2S frames at BCLK=clk/16 and checks the
// output stream against a frame-level model held in a scoreboard queue.
module tb_i2s_audio_receiver;

  localparam int DW    = 24;
  localparam int DEPTH = 4;
  localparam int HALF  = 8;

  logic clk = 1'b0;
  logic reset_n, enable, i2s_bclk, i2s_lrclk, i2s_din, out_ready, overrun_clear;
  logic [DW-1:0] out_left, out_right;
  logic out_valid, locked, overrun;
  logic [$clog2(DEPTH+1)-1:0] fifo_level;

  always #5 clk = ~clk;

  i2s_audio_receiver #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .i2s_bclk(i2s_bclk), .i2s_lrclk(i2s_lrclk), .i2s_din(i2s_din),
    .out_left(out_left), .out_right(out_right), .out_valid(out_valid),
    .out_ready(out_ready), .fifo_level(fifo_level), .locked(locked),
    .overrun(overrun), .overrun_clear(overrun_clear)
  );

  typedef struct packed {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
  } frame_t;

  frame_t exp_q[$];
  int     checks = 0;
  int     errors = 0;

  bit     exp_overrun, locked_m, saw_right, cur_ok, pend_ok, closed, rand_ready;
  logic   pending;
  frame_t cur_f, pend_f;
  int     reset_at  = -1;
  int     enable_at = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Words are MSB-aligned into DW bits: truncated if the slot is longer, zero-padded if shorter.
  function automatic logic [DW-1:0] align(input logic [31:0] w, input int s);
    logic [63:0] x;
    x = {32'd0, w};
    if (s >= DW) return DW'(x >> (s - DW));
    else         return DW'(x << (DW - s));
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic period(input logic lr, input logic d, input bit lat, input bit clr);
    i2s_bclk  = 1'b0;
    i2s_lrclk = lr;
    i2s_din   = d;
    tick(HALF);
    i2s_bclk = 1'b1;
    for (int k = 1; k <= HALF; k++) begin
      tick(1);
      if (clr && k == 4) overrun_clear = 1'b1;
      if (clr && k == 5) overrun_clear = 1'b0;
      if (lat && k == 4) check("valid_latency_early", 64'(out_valid), 64'd0);
      if (lat && k == 5) check("valid_latency", 64'(out_valid), 64'd1);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    exp_q.delete();
    exp_overrun = 0; locked_m = 0; saw_right = 0; cur_ok = 0; pend_ok = 0;
    tick(1);
    check("rst_out_left",   64'(out_left),   64'd0);
    check("rst_out_right",  64'(out_right),  64'd0);
    check("rst_out_valid",  64'(out_valid),  64'd0);
    check("rst_fifo_level", 64'(fifo_level), 64'd0);
    check("rst_locked",     64'(locked),     64'd0);
    check("rst_overrun",    64'(overrun),    64'd0);
    tick(2);
    reset_n = 1'b1;
  endtask

  task automatic set_enable(input bit v);
    enable = v;
    if (!v) begin
      locked_m = 0;
      cur_ok   = 0;
    end
  endtask

  task automatic commit_model();
    if (pend_ok) begin
      if (exp_q.size() < DEPTH) exp_q.push_back(pend_f);
      else                      exp_overrun = 1;
    end
    pend_ok = 0;
  endtask

  // A left slot start with LRCLK previously high is what the receiver locks onto.
  task automatic left_start();
    if (!locked_m && enable && saw_right) locked_m = 1;
    cur_ok    = locked_m && enable;
    saw_right = 0;
  endtask

  task automatic send_frame(input logic [31:0] lw, input logic [31:0] rw, input int s);
    if (!closed) begin
      commit_model();
      left_start();
      period(1'b0, pending, 0, 0);
    end
    closed  = 0;
    cur_f.l = align(lw, s);
    cur_f.r = align(rw, s);
    for (int j = 1; j < s; j++) begin
      if (j == reset_at) do_reset();
      period(1'b0, lw[s-j], 0, 0);
    end
    period(1'b1, lw[0], 0, 0);
    for (int j = 1; j < s; j++) begin
      if (j == enable_at) set_enable(1);
      period(1'b1, rw[s-j], 0, 0);
    end
    saw_right = 1;
    pending   = rw[0];
    pend_ok   = cur_ok;
    pend_f    = cur_f;
  endtask

  task automatic close(input bit lat, input bit clr);
    commit_model();
    left_start();
    period(1'b0, pending, lat, clr);
    closed = 1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin
      tick(1);
      n++;
    end
    check("drain_in_time", 64'(n < 400), 64'd1);
    check("drain_level", 64'(fifo_level), 64'd0);
  endtask

  initial begin : monitor
    frame_t f;
    forever begin
      @(negedge clk);
      #1;
      if (reset_n === 1'b1 && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL frame_unexpected actual=%0h/%0h required=none", out_left, out_right);
        end else begin
          f = exp_q.pop_front();
          check("frame_left",  64'(out_left),  64'(f.l));
          check("frame_right", 64'(out_right), 64'(f.r));
        end
      end
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [31:0] lw, rw;
    int s;
    i2s_bclk = 0; i2s_lrclk = 0; i2s_din = 0;
    out_ready = 1; overrun_clear = 0; enable = 1; rand_ready = 0;
    pending = 0; closed = 0;
    do_reset();

    send_frame($urandom, $urandom, 32);
    send_frame(32'hA5A5A5A5, 32'h12345678, 32);
    close(1, 0);
    tick(10);
    check("locked_after_lock", 64'(locked), 64'(locked_m));

    set_enable(0);
    tick(4);
    check("locked_disabled", 64'(locked), 64'd0);
    enable_at = 10;
    send_frame($urandom, $urandom, 32);
    enable_at = -1;
    check("locked_before_edge", 64'(locked), 64'(locked_m));
    send_frame($urandom, $urandom, 32);
    check("locked_after_edge", 64'(locked), 64'(locked_m));

    send_frame(32'h0000BEEF, 32'h00000001, 16);
    close(0, 0);
    tick(10);

    reset_at = 5;
    send_frame($urandom, $urandom, 32);
    reset_at = -1;
    send_frame($urandom, $urandom, 32);
    close(0, 0);
    tick(10);

    out_ready = 0;
    for (int n = 1; n <= 5; n++) send_frame(32'(n), 32'(n + 'h100), 24);
    close(0, 0);
    tick(10);
    check("ovf_level", 64'(fifo_level), 64'(exp_q.size()));
    check("ovf_overrun", 64'(overrun), 64'(exp_overrun));
    send_frame(32'd6, 32'h106, 24);
    close(0, 1);
    tick(4);
    check("ovf_clear_collide", 64'(overrun), 64'(exp_overrun));
    overrun_clear = 1;
    tick(1);
    overrun_clear = 0;
    exp_overrun = 0;
    tick(1);
    check("ovf_clear_quiet", 64'(overrun), 64'(exp_overrun));
    out_ready = 1;
    wait_drain();

    rand_ready = 1;
    for (int n = 0; n < 8; n++) begin
      case ($urandom_range(0, 3))
        0:       s = 16;
        1:       s = 20;
        2:       s = 24;
        default: s = 32;
      endcase
      lw = $urandom;
      rw = $urandom;
      if (s < 32) begin
        lw = lw & 32'((64'd1 << s) - 1);
        rw = rw & 32'((64'd1 << s) - 1);
      end
      send_frame(lw, rw, s);
    end
    close(0, 0);
    rand_ready = 0;
    out_ready  = 1;
    wait_drain();
    check("final_overrun", 64'(overrun), 64'(exp_overrun));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
